// File: rtl/fifo_stream_unload_if.sv
// Valid/ready stream bundle carried out of fifo_stream_unload.
// The master drives data and valid, and the slave answers with ready.
interface fifo_stream_unload_if #(
  parameter int dwidth = 8
);
  logic [dwidth-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_stream_unload.sv
// Pops a FIFO with a registered one-cycle read and re-presents its words as a
// valid/ready stream through a 2-entry buffer; also counts delivered words.
module fifo_stream_unload #(
  parameter int dwidth = 8,
  parameter int cwidth = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [dwidth-1:0]     fifo_dout,
  input  logic                  fifo_rdy,
  output logic                  fifo_pop,
  input  logic                  flush,
  fifo_stream_unload_if.master  m,
  output logic [cwidth-1:0]     xfer_cnt
);

  logic [1:0]        occ;
  logic [1:0]        occ_next;
  logic [1:0]        keep;
  logic              inflight;
  logic              take;
  logic [dwidth-1:0] buf0;
  logic [dwidth-1:0] buf1;
  logic [dwidth-1:0] buf0_next;
  logic [dwidth-1:0] buf1_next;

  assign m.m_valid = (occ != 2'd0);
  assign m.m_data  = buf0;

  // keep = entries surviving this cycle's handshake; the arriving word lands behind them.
  // Popping depends on m_ready so a full-rate stream never leaves a bubble.
  always_comb begin
    take      = m.m_valid & m.m_ready;
    keep      = occ - {1'b0, take};
    fifo_pop  = fifo_rdy & ~flush & ~reset &
                (({1'b0, keep} + {2'b00, inflight}) < 3'd2);
    buf0_next = take ? buf1 : buf0;
    buf1_next = buf1;
    if (inflight && !flush) begin
      if (keep == 2'd0) buf0_next = fifo_dout;
      else              buf1_next = fifo_dout;
    end
    occ_next  = flush ? 2'd0 : (keep + {1'b0, inflight});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ      <= '0;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
      xfer_cnt <= '0;
    end else begin
      occ      <= occ_next;
      inflight <= fifo_pop;
      buf0     <= buf0_next;
      buf1     <= buf1_next;
      xfer_cnt <= xfer_cnt + cwidth'(take);
    end
  end

endmodule

// File: tb/tb_fifo_stream_unload.sv
// Bench for fifo_stream_unload: a queue-based FIFO source with registered read and
// a scoreboard of popped-but-undelivered words; a narrow-counter twin shares stimulus.
module tb_fifo_stream_unload;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] fifo_dout;
  logic       fifo_rdy;
  logic       fifo_pop;
  logic       pop4;
  logic       flush;
  logic       ready;
  logic [15:0] xfer_cnt;
  logic [3:0]  xfer4;

  fifo_stream_unload_if #(.dwidth(8)) bus ();
  fifo_stream_unload_if #(.dwidth(8)) bus4 ();
  assign bus.m_ready  = ready;
  assign bus4.m_ready = ready;

  fifo_stream_unload #(.dwidth(8), .cwidth(16)) dut (
    .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_rdy(fifo_rdy),
    .fifo_pop(fifo_pop), .flush(flush), .m(bus), .xfer_cnt(xfer_cnt));

  fifo_stream_unload #(.dwidth(8), .cwidth(4)) dut4 (
    .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_rdy(fifo_rdy),
    .fifo_pop(pop4), .flush(flush), .m(bus4), .xfer_cnt(xfer4));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int takes, pops, dropped;
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Source FIFO: registered read, word appears on fifo_dout after the popping edge.
  always @(posedge clk) begin
    if (!reset && fifo_pop) begin
      if (src_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_empty: popped with source empty (t=%0t)", $time);
      end else begin
        fifo_dout <= src_q[0];
        exp_q.push_back(src_q[0]);
        src_q.pop_front();
        pops++;
      end
    end
  end

  task automatic set_rdy();
    fifo_rdy = (src_q.size() != 0);
  endtask

  // One clock period starting just after a negedge with inputs already applied.
  task automatic cycle();
    logic fl;
    #1;
    chk("pop_without_rdy", {31'd0, (fifo_pop | pop4) & ~fifo_rdy}, 0);
    chk("outstanding_le_2", {31'd0, exp_q.size() <= 2}, 1);
    if (flush) chk("pop_in_flush", {31'd0, fifo_pop}, 0);
    if (bus.m_valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_word", 1, 0);
      end else begin
        chk("data_order", bus.m_data, exp_q[0]);
        chk("w4_valid", {31'd0, bus4.m_valid}, 1);
        chk("w4_data", bus4.m_data, exp_q[0]);
        exp_q.pop_front();
        takes++;
      end
    end
    fl = flush;
    @(posedge clk);
    #1;
    if (fl) begin
      dropped += exp_q.size();
      exp_q.delete();
    end
    chk("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, takes[15:0]});
    chk("xfer_cnt_w4", {28'd0, xfer4}, {28'd0, takes[3:0]});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    fifo_rdy = 1'b1;
    flush    = 1'b0;
    ready    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_valid", {31'd0, bus.m_valid}, 0);
    chk("rst_fifo_pop", {31'd0, fifo_pop}, 0);
    chk("rst_xfer_cnt", {16'd0, xfer_cnt}, 0);
    chk("rst_m_data", {24'd0, bus.m_data}, 0);
    chk("rst_xfer_w4", {28'd0, xfer4}, 0);
    src_q.delete();
    exp_q.delete();
    takes = 0;
    pops = 0;
    dropped = 0;
    @(negedge clk);
    reset    = 1'b0;
    fifo_rdy = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && (src_q.size() != 0 || exp_q.size() != 0); i++) begin
      set_rdy();
      cycle();
    end
    chk("drain_done", src_q.size() + exp_q.size(), 0);
  endtask

  typedef struct {
    logic       rdy_in;
    logic       exp_pop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bit   got;
    bit   done;
    int   pushed;
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h11, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h22, 1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h33, 2};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h44, 3};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 4};

    reset = 1'b1;
    flush = 1'b0;
    ready = 1'b0;
    fifo_rdy = 1'b0;
    fifo_dout = 8'h00;
    @(negedge clk);
    do_reset();

    // Streaming at full rate: latency 2 and one word per cycle.
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (tbl[i]) begin
      ready = tbl[i].rdy_in;
      set_rdy();
      #1;
      chk($sformatf("t2_pop_c%0d", i), {31'd0, fifo_pop}, {31'd0, tbl[i].exp_pop});
      chk($sformatf("t2_valid_c%0d", i), {31'd0, bus.m_valid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid)
        chk($sformatf("t2_data_c%0d", i), {24'd0, bus.m_data}, {24'd0, tbl[i].exp_data});
      chk($sformatf("t2_cnt_c%0d", i), {16'd0, xfer_cnt}, tbl[i].exp_cnt);
      cycle();
    end

    // Reset after traffic clears held data and counter.
    do_reset();

    // Back-pressure: only two words outstanding, head held, then full release.
    src_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    ready = 1'b0;
    repeat (8) begin
      set_rdy();
      cycle();
    end
    set_rdy();
    #1;
    chk("bp_pops", pops, 2);
    chk("bp_pop_now", {31'd0, fifo_pop}, 0);
    chk("bp_valid", {31'd0, bus.m_valid}, 1);
    chk("bp_head", {24'd0, bus.m_data}, 32'hA0);
    ready = 1'b1;
    drain(30);
    chk("bp_delivered", takes, 6);
    chk("bp_pops_total", pops, 6);

    // Flush with one word buffered and one in flight, consumer stalled.
    do_reset();
    src_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
    ready = 1'b0;
    set_rdy();
    cycle();
    set_rdy();
    cycle();
    set_rdy();
    #1;
    chk("fl_pre_valid", {31'd0, bus.m_valid}, 1);
    chk("fl_pre_head", {24'd0, bus.m_data}, 32'hB0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    set_rdy();
    #1;
    chk("fl_valid_after", {31'd0, bus.m_valid}, 0);
    chk("fl_cnt_after", {16'd0, xfer_cnt}, 0);
    ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      set_rdy();
      #1;
      if (bus.m_valid) got = 1'b1;
      else cycle();
    end
    chk("fl_next_valid", {31'd0, got}, 1);
    chk("fl_next_word", {24'd0, bus.m_data}, 32'hB2);
    drain(30);
    chk("fl_delivered", takes, 6);

    // Counter wrap on the 4-bit twin.
    do_reset();
    for (int i = 0; i < 17; i++) src_q.push_back(8'(i * 3 + 1));
    ready = 1'b1;
    drain(40);
    chk("wrap_w4", {28'd0, xfer4}, 1);
    chk("wrap_w16", {16'd0, xfer_cnt}, 17);

    // Random availability, back-pressure and occasional flush over 10k words.
    do_reset();
    pushed = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
      if (pushed < 10000 && ($urandom % 4) != 0) begin
        src_q.push_back(8'($urandom));
        pushed++;
      end
      ready = (($urandom % 4) != 0);
      flush = (($urandom % 64) == 0);
      set_rdy();
      cycle();
      done = (pushed == 10000) && (src_q.size() == 0) && (exp_q.size() == 0);
    end
    flush = 1'b0;
    chk("rand_finished", {31'd0, done}, 1);
    chk("rand_accounted", takes + dropped, 10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
